gcbp_bram_reader: RTL and testbench

GCBP_BRAM_READER -- requirements
Module: gcbp_bram_reader

---
 rtl/gcbp_bram_reader_if.sv | 49 ++++
 rtl/gcbp_bram_reader.sv | 167 ++++++++++++++++
 tb/tb_gcbp_bram_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcbp_bram_reader_if.sv
// rtl/gcbp_bram_reader_if.sv - control, BRAM read bus and line-pair stream of the BRAM reader
//
// Purpose: bundles every non-clock/reset signal of gcbp_bram_reader.
// Ports (signal groups):
//   control : i_start, i_curr_frame_loc, i_prev_frame_loc, i_new_frame
//   bram    : o_bram_array_read_addr, i_bram_array_read_data
//   stream  : o_curr_line, o_prev_line, o_subimage_idx, o_row, o_valid, i_ready
//   status  : o_busy, o_done, o_err, o_overrun
// Modports: master = reader side, slave = environment side.

interface gcbp_bram_reader_if #(
   parameter int C_NUM_SUBIMAGES = 16,
   parameter int C_LINE_W        = 128
);
   logic                                  i_start;
   logic [1:0]                            i_curr_frame_loc;
   logic [1:0]                            i_prev_frame_loc;
   logic                                  i_new_frame;
   logic [8:0]                            o_bram_array_read_addr;
   logic [C_NUM_SUBIMAGES*C_LINE_W-1:0]   i_bram_array_read_data;
   logic [C_LINE_W-1:0]                   o_curr_line;
   logic [C_LINE_W-1:0]                   o_prev_line;
   logic [3:0]                            o_subimage_idx;
   logic [5:0]                            o_row;
   logic                                  o_valid;
   logic                                  i_ready;
   logic                                  o_busy;
   logic                                  o_done;
   logic                                  o_err;
   logic                                  o_overrun;

   modport master (
      input  i_start, i_curr_frame_loc, i_prev_frame_loc, i_new_frame,
      output o_bram_array_read_addr,
      input  i_bram_array_read_data,
      output o_curr_line, o_prev_line, o_subimage_idx, o_row, o_valid,
      input  i_ready,
      output o_busy, o_done, o_err, o_overrun
   );

   modport slave (
      output i_start, i_curr_frame_loc, i_prev_frame_loc, i_new_frame,
      input  o_bram_array_read_addr,
      output i_bram_array_read_data,
      input  o_curr_line, o_prev_line, o_subimage_idx, o_row, o_valid,
      output i_ready,
      input  o_busy, o_done, o_err, o_overrun
   );
endinterface

// File: rtl/gcbp_bram_reader.sv
// rtl/gcbp_bram_reader.sv - pairs previous/current frame lines from a sub-image BRAM array
//
// Purpose: on i_start, walks every sub-image (BRAM) and row, reading the previous-frame
// line then the current-frame line of the same row, and presents them as one pair.
// Ports:
//   i_clk    : clock, rising edge
//   i_resetn : synchronous, active-low reset
//   bus      : gcbp_bram_reader_if.master (control, BRAM read bus, pair stream, status)

module gcbp_bram_reader #(
   parameter int C_ROWS          = 64,
   parameter int C_NUM_SUBIMAGES = 16,
   parameter int C_LINE_W        = 128
) (
   input  logic                 i_clk,
   input  logic                 i_resetn,
   gcbp_bram_reader_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_PREV,
      S_RD_CURR,
      S_CAPTURE,
      S_OUTPUT
   } state_t;

   localparam logic [5:0] LAST_ROW = 6'(C_ROWS - 1);
   localparam logic [3:0] LAST_IDX = 4'(C_NUM_SUBIMAGES - 1);

   state_t                state_q, state_d;
   logic [1:0]            curr_loc_q, curr_loc_d;
   logic [1:0]            prev_loc_q, prev_loc_d;
   logic [3:0]            idx_q, idx_d;
   logic [5:0]            row_q, row_d;
   logic [8:0]            addr_q, addr_d;
   logic [C_LINE_W-1:0]   curr_line_q, curr_line_d;
   logic [C_LINE_W-1:0]   prev_line_q, prev_line_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  overrun_q, overrun_d;

   logic [C_LINE_W-1:0]   sel_line;
   logic                  xfer;
   logic                  last_pair;

   // All BRAMs see the same address; only the current sub-image's slice matters.
   assign sel_line  = bus.i_bram_array_read_data[int'(idx_q) * C_LINE_W +: C_LINE_W];
   assign xfer      = (state_q == S_OUTPUT) && bus.i_ready;
   assign last_pair = (idx_q == LAST_IDX) && (row_q == LAST_ROW);

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state_q     <= S_IDLE;
         curr_loc_q  <= '0;
         prev_loc_q  <= '0;
         idx_q       <= '0;
         row_q       <= '0;
         addr_q      <= '0;
         curr_line_q <= '0;
         prev_line_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         curr_loc_q  <= curr_loc_d;
         prev_loc_q  <= prev_loc_d;
         idx_q       <= idx_d;
         row_q       <= row_d;
         addr_q      <= addr_d;
         curr_line_q <= curr_line_d;
         prev_line_q <= prev_line_d;
         done_q      <= done_d;
         err_q       <= err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      curr_loc_d  = curr_loc_q;
      prev_loc_d  = prev_loc_q;
      idx_d       = idx_q;
      row_d       = row_q;
      addr_d      = addr_q;
      curr_line_d = curr_line_q;
      prev_line_d = prev_line_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               if (bus.i_curr_frame_loc == bus.i_prev_frame_loc) begin
                  err_d = 1'b1;
               end else begin
                  curr_loc_d = bus.i_curr_frame_loc;
                  prev_loc_d = bus.i_prev_frame_loc;
                  idx_d      = '0;
                  row_d      = '0;
                  state_d    = S_RD_PREV;
               end
            end
         end
         S_RD_PREV: begin
            state_d = S_RD_CURR;
         end
         S_RD_CURR: begin
            // Data on the bus now answers the previous-frame address.
            prev_line_d = sel_line;
            state_d     = S_CAPTURE;
         end
         S_CAPTURE: begin
            curr_line_d = sel_line;
            state_d     = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (bus.i_ready) begin
               if (last_pair) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  if (row_q == LAST_ROW) begin
                     row_d = '0;
                     idx_d = idx_q + 4'd1;
                  end else begin
                     row_d = row_q + 6'd1;
                  end
                  state_d = S_RD_PREV;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A frame boundary coinciding with the final transfer is a normal completion.
      if ((state_q != S_IDLE) && bus.i_new_frame && !(xfer && last_pair)) begin
         state_d   = S_IDLE;
         overrun_d = 1'b1;
         idx_d     = idx_q;
         row_d     = row_q;
      end

      // Address is registered one state ahead so it is on the bus during the read state.
      if (state_d == S_RD_PREV) begin
         addr_d = {prev_loc_d, 1'b0, row_d};
      end else if (state_d == S_RD_CURR) begin
         addr_d = {curr_loc_q, 1'b0, row_q};
      end
   end

   assign bus.o_bram_array_read_addr = addr_q;
   assign bus.o_curr_line            = curr_line_q;
   assign bus.o_prev_line            = prev_line_q;
   assign bus.o_subimage_idx         = idx_q;
   assign bus.o_row                  = row_q;
   assign bus.o_valid                = (state_q == S_OUTPUT);
   assign bus.o_busy                 = (state_q != S_IDLE);
   assign bus.o_done                 = done_q;
   assign bus.o_err                  = err_q;
   assign bus.o_overrun              = overrun_q;

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// tb/tb_gcbp_bram_reader.sv - self-checking bench for gcbp_bram_reader

module tb_gcbp_bram_reader;
   localparam int ROWS = 64;
   localparam int NSUB = 16;
   localparam int LW   = 128;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   gcbp_bram_reader_if #(.C_NUM_SUBIMAGES(NSUB), .C_LINE_W(LW)) bus ();

   gcbp_bram_reader #(.C_ROWS(ROWS), .C_NUM_SUBIMAGES(NSUB), .C_LINE_W(LW)) dut (
      .i_clk    (clk),
      .i_resetn (resetn),
      .bus      (bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] curr;
      logic [1:0] prev;
      logic       exp_err;
      logic [8:0] exp_a0;
      logic [8:0] exp_a1;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [LW-1:0] bram_val(input int k, input logic [8:0] a);
      logic [7:0] kb;
      kb = 8'(k);
      if (k == 5 && a == 9'h011) return 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      if (k == 5 && a == 9'h091) return 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_ABCD;
      return {4{kb, 15'd0, a}};
   endfunction

   // Registered BRAM array: data follows the address by one cycle.
   always @(posedge clk) begin
      for (int k = 0; k < NSUB; k++)
         bus.i_bram_array_read_data[k*LW +: LW] <= bram_val(k, bus.o_bram_array_read_addr);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_addr"}, 128'(bus.o_bram_array_read_addr), 128'd0);
      chk({tag, "_curr_line"}, bus.o_curr_line, 128'd0);
      chk({tag, "_prev_line"}, bus.o_prev_line, 128'd0);
      chk({tag, "_idx_row"}, 128'({bus.o_subimage_idx, bus.o_row}), 128'd0);
      chk({tag, "_flags"}, 128'({bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.o_overrun}), 128'd0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      resetn = 1'b0;
      bus.i_start = 1'b0;
      bus.i_new_frame = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic start_pass(input logic [1:0] curr, input logic [1:0] prev);
      @(negedge clk);
      bus.i_curr_frame_loc = curr;
      bus.i_prev_frame_loc = prev;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      // Changing the inputs must not disturb a pass that already latched them.
      bus.i_curr_frame_loc = ~curr;
      bus.i_prev_frame_loc = ~curr;
   endtask

   task automatic wait_valid(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(name, 128'(ok), 128'd1);
   endtask

   // mode 0: full pass, i_new_frame on the final transfer
   // mode 1: i_new_frame at transfer 300
   // mode 2: reset during transfer 500
   task automatic run_pass(input int mode);
      int k, xfers, bad, done_k;
      bit hit, saw_overrun;
      logic [LW-1:0] p517, c517;
      bus.i_ready = 1'b1;
      start_pass(2'd1, 2'd0);
      k = 0; xfers = 0; bad = 0; done_k = -1; hit = 0; saw_overrun = 0;
      p517 = '0; c517 = '0;
      while (k < 5000) begin
         if (mode == 0 && k == 0) chk("pass_addr0", 128'(bus.o_bram_array_read_addr), 128'h000);
         if (mode == 0 && k == 1) chk("pass_addr1", 128'(bus.o_bram_array_read_addr), 128'h080);
         if (bus.o_overrun) saw_overrun = 1'b1;
         if (bus.o_done) begin
            done_k = k;
            break;
         end
         if (bus.o_valid) begin
            if (bus.o_subimage_idx != 4'(xfers / ROWS) || bus.o_row != 6'(xfers % ROWS)) bad++;
            if (bus.o_prev_line !== bram_val(xfers / ROWS, {2'd0, 1'b0, 6'(xfers % ROWS)})) bad++;
            if (bus.o_curr_line !== bram_val(xfers / ROWS, {2'd1, 1'b0, 6'(xfers % ROWS)})) bad++;
            if (xfers == 5*ROWS + 17) begin
               p517 = bus.o_prev_line;
               c517 = bus.o_curr_line;
            end
            if (mode == 1 && xfers == 300) begin
               bus.i_new_frame = 1'b1;
               hit = 1'b1;
               break;
            end
            if (mode == 2 && xfers == 500) begin
               resetn = 1'b0;
               hit = 1'b1;
               break;
            end
            if (mode == 0 && xfers == NSUB*ROWS - 1) bus.i_new_frame = 1'b1;
            xfers++;
         end
         @(negedge clk);
         bus.i_new_frame = 1'b0;
         k++;
      end
      if (mode == 0) begin
         chk("pass_done_cycle", 128'(done_k), 128'd4096);
         chk("pass_xfer_count", 128'(xfers), 128'(NSUB*ROWS));
         chk("pass_order_data", 128'(bad), 128'd0);
         chk("pass_no_overrun", 128'({saw_overrun, bus.o_overrun}), 128'd0);
         chk("bram5_row17_prev", p517, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
         chk("bram5_row17_curr", c517, 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_ABCD);
         @(negedge clk);
         chk("pass_done_pulse", 128'({bus.o_done, bus.o_busy, bus.o_valid}), 128'd0);
      end else if (mode == 1) begin
         chk("abort_reached", 128'(hit), 128'd1);
         chk("abort_order_data", 128'(bad), 128'd0);
         @(negedge clk);
         bus.i_new_frame = 1'b0;
         chk("abort_flags", 128'({bus.o_valid, bus.o_overrun, bus.o_busy, bus.o_done}), 128'b0100);
         @(negedge clk);
         chk("abort_pulse_end", 128'({bus.o_overrun, bus.o_busy, bus.o_done}), 128'd0);
         start_pass(2'd1, 2'd0);
         wait_valid("restart_valid");
         chk("restart_idx_row", 128'({bus.o_subimage_idx, bus.o_row}), 128'd0);
      end else begin
         chk("reset_reached", 128'(hit), 128'd1);
         @(negedge clk);
         chk_idle_zero("midreset");
         resetn = 1'b1;
         bad = 0;
         repeat (6) begin
            @(negedge clk);
            if (bus.o_done || bus.o_overrun || bus.o_busy) bad++;
         end
         chk("midreset_quiet", 128'(bad), 128'd0);
      end
   endtask

   initial begin
      logic [LW-1:0] c0, p0;
      logic [3:0]    i0;
      logic [5:0]    r0;
      bit            stable;

      tbl[0] = '{curr: 2'd1, prev: 2'd0, exp_err: 1'b0, exp_a0: 9'h000, exp_a1: 9'h080};
      tbl[1] = '{curr: 2'd2, prev: 2'd2, exp_err: 1'b1, exp_a0: 9'h000, exp_a1: 9'h000};
      tbl[2] = '{curr: 2'd3, prev: 2'd1, exp_err: 1'b0, exp_a0: 9'h080, exp_a1: 9'h180};
      tbl[3] = '{curr: 2'd0, prev: 2'd3, exp_err: 1'b0, exp_a0: 9'h180, exp_a1: 9'h000};
      tbl[4] = '{curr: 2'd0, prev: 2'd0, exp_err: 1'b1, exp_a0: 9'h000, exp_a1: 9'h000};
      tbl[5] = '{curr: 2'd2, prev: 2'd1, exp_err: 1'b0, exp_a0: 9'h080, exp_a1: 9'h100};

      bus.i_start = 1'b0;
      bus.i_new_frame = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_curr_frame_loc = 2'd0;
      bus.i_prev_frame_loc = 2'd0;

      repeat (3) @(negedge clk);
      chk_idle_zero("reset");
      resetn = 1'b1;

      // Frame boundary while idle is ignored.
      @(negedge clk);
      bus.i_new_frame = 1'b1;
      @(negedge clk);
      bus.i_new_frame = 1'b0;
      chk("idle_new_frame", 128'({bus.o_busy, bus.o_overrun, bus.o_valid}), 128'd0);

      for (int v = 0; v < 6; v++) begin
         reset_dut();
         bus.i_ready = 1'b0;
         start_pass(tbl[v].curr, tbl[v].prev);
         chk($sformatf("vec%0d_err", v), 128'(bus.o_err), 128'(tbl[v].exp_err));
         chk($sformatf("vec%0d_busy", v), 128'(bus.o_busy), 128'(!tbl[v].exp_err));
         chk($sformatf("vec%0d_addr0", v), 128'(bus.o_bram_array_read_addr), 128'(tbl[v].exp_a0));
         @(negedge clk);
         if (tbl[v].exp_err) begin
            chk($sformatf("vec%0d_err_end", v),
                128'({bus.o_err, bus.o_busy, bus.o_valid, bus.o_bram_array_read_addr}), 128'd0);
         end else begin
            chk($sformatf("vec%0d_addr1", v), 128'(bus.o_bram_array_read_addr), 128'(tbl[v].exp_a1));
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_valid", v), 128'(bus.o_valid), 128'd1);
            chk($sformatf("vec%0d_prev", v), bus.o_prev_line, bram_val(0, tbl[v].exp_a0));
            chk($sformatf("vec%0d_curr", v), bus.o_curr_line, bram_val(0, tbl[v].exp_a1));
            bus.i_new_frame = 1'b1;
            @(negedge clk);
            bus.i_new_frame = 1'b0;
            chk($sformatf("vec%0d_abort", v),
                128'({bus.o_valid, bus.o_overrun, bus.o_busy, bus.o_done}), 128'b0100);
         end
      end

      // Backpressure: hold 10 cycles, start while busy ignored, exactly one transfer.
      reset_dut();
      bus.i_ready = 1'b0;
      start_pass(2'd1, 2'd0);
      wait_valid("hold_valid");
      c0 = bus.o_curr_line; p0 = bus.o_prev_line;
      i0 = bus.o_subimage_idx; r0 = bus.o_row;
      chk("hold_first_pair", 128'({i0, r0}), 128'd0);
      bus.i_curr_frame_loc = 2'd2;
      bus.i_prev_frame_loc = 2'd3;
      bus.i_start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         stable = bus.o_valid && bus.o_curr_line === c0 && bus.o_prev_line === p0 &&
                  bus.o_subimage_idx == i0 && bus.o_row == r0 && !bus.o_err;
         chk($sformatf("hold_stable_%0d", c), 128'(stable), 128'd1);
         @(negedge clk);
         bus.i_start = 1'b0;
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_ready = 1'b0;
      chk("hold_released", 128'(bus.o_valid), 128'd0);
      wait_valid("hold_next_valid");
      chk("hold_single_xfer", 128'({bus.o_subimage_idx, bus.o_row}), 128'd1);
      chk("hold_latched_prev", bus.o_prev_line, bram_val(0, 9'h001));
      chk("hold_latched_curr", bus.o_curr_line, bram_val(0, 9'h081));

      reset_dut();
      run_pass(0);
      reset_dut();
      run_pass(1);
      reset_dut();
      run_pass(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
